reu_dma_engine: RTL
===================

Name: reu_dma_engine

Overview:
- DMA transfer sequencer for the REU: the initiator side of the REU register block.
- Consumes Execute, transfer type, current C64/REU addresses and Length1 from the register block.
- Masters the C64 bus via nDMA/BA and drives expansion SRAM strobes.
- Returns NextCA, NextREUA and VerifyErr pulses, which the register block uses to advance addresses and length, and to set status.

Parameters:
- None. Widths are fixed by the register block: CA 16 bits, REUA 24 bits.

Ports:
PHI2  in  1  C64 system clock; all state updates on falling edge
Reset  in  1  reset; synchronous, active-high
ExecuteEN  in  1  command bit 7 from the register block
FF00DecodeEN  in  1  start deferred until CPU write to $FF00
XferType  in  2  00 stash C64->REU, 01 fetch REU->C64, 10 swap, 11 verify
Length1  in  1  remaining length equals 1, so the current byte is the last
CA  in  16  current C64 address
REUA  in  24  current REU address
FF00Wr  in  1  decoded CPU write to $FF00, valid during PHI2 high
BA  in  1  VIC bus-available; low = bus not free
C64DIn  in  8  C64 data bus input
REUDIn  in  8  SRAM read data (async SRAM, valid within the cycle)
nDMA  out  1  C64 DMA request, active-low
C64AOE  out  1  drive CA onto the C64 address bus
C64RW  out  1  C64 R/W (1 = read)
C64DOE  out  1  drive C64DOut onto the C64 data bus
C64DOut  out  8  write data to C64
RAMA  out  24  SRAM address (= REUA)
RAMnOE  out  1  SRAM output enable, active-low
RAMnWE  out  1  SRAM write enable, active-low
RAMDOut  out  8  SRAM write data
NextCA  out  1  one-cycle advance pulse for CA and length
NextREUA  out  1  one-cycle advance pulse for REUA
VerifyErr  out  1  one-cycle verify mismatch pulse
Busy  out  1  state is not IDLE
XferDone  out  1  one-cycle completion pulse

Behaviour:
- Timing: state and all registers update on negedge PHI2. Strobes and Next* are decoded combinationally from state and inputs during PHI2 high, so the register block samples them at the same falling edge that ends the data phase.
- Reset: state=IDLE; ExecPrev=0; latches=0.
- Reset values of outputs: nDMA=1, C64AOE=0, C64DOE=0, C64RW=1, RAMnOE=1, RAMnWE=1, NextCA=NextREUA=VerifyErr=XferDone=Busy=0, C64DOut=RAMDOut=0.
- Start condition: an ExecuteEN rising edge (ExecuteEN && !ExecPrev); a level held across DONE does not restart.
- States:
  - IDLE: on start, go to ARM if FF00DecodeEN, else WAITBA.
  - ARM: nDMA=1. FF00Wr -> WAITBA. ExecuteEN low -> IDLE.
  - WAITBA: nDMA=0, no strobes. BA high -> XFER (types 00/01/11) or SWAP_RD (type 10).
  - XFER, one byte per cycle, C64AOE=1:
    - Stash: C64RW=1, RAMnWE=0, RAMDOut=C64DIn.
    - Fetch: RAMnOE=0, C64RW=0, C64DOE=1, C64DOut=REUDIn.
    - Verify: C64RW=1, RAMnOE=0, compare C64DIn vs REUDIn.
  - SWAP_RD: C64 read and SRAM read. Latch both bytes at negedge. No Next pulses.
  - SWAP_WR: write the latched C64 byte to SRAM and the latched SRAM byte to C64. Next pulses here; return to SWAP_RD.
  - DONE: nDMA=1, XferDone=1 for one cycle, then IDLE.
- Byte completion (XFER cycle, or SWAP_WR): NextCA=NextREUA=1. If Length1 is high in that cycle -> DONE, else continue.
- Length==1 at start gives exactly one byte.
- BA low in XFER or SWAP states: stall in place. Hold nDMA=0; C64AOE=0, all strobes inactive, no Next pulses; swap latches are held.
- Verify mismatch:
  - VerifyErr=1 that cycle; NextCA and NextREUA suppressed; go to DONE.
  - A mismatch on the last byte also takes this path.
- ExecuteEN cleared externally mid-transfer is ignored. Only Reset aborts.
- Reset mid-operation: IDLE on that edge; bus released immediately, no XferDone.
- ExecPrev tracks ExecuteEN every edge, including during reset.

Optional Feature:
- Macro: REU_VERIFY_EN.
- Defined: XferType 11 performs verify as above.
- Undefined:
  - Type 11 passes WAITBA -> DONE with no bus cycles, no Next pulses and VerifyErr tied 0.
  - Compare logic is omitted.

Test Plan:
- Stash: CA=1000h, REUA=020000h, length 3, no FF00 -> WAITBA one cycle, then 3 cycles RAMnWE=0 with RAMDOut=C64 data, 3 NextCA/NextREUA pulses, XferDone, nDMA=1.
- Fetch with FF00DecodeEN: engine holds ARM with nDMA=1 for 10 cycles; FF00Wr -> nDMA=0, one byte C64DOut=REUDIn=5Ah, C64RW=0, DONE.
- Swap 2 bytes (C64 11h,22h; REU AAh,BBh) -> 4 cycles RD/WR/RD/WR; C64 receives AAh,BBh; SRAM receives 11h,22h; 2 Next pulses, only in WR cycles.
- Verify 4 bytes, byte 2 mismatches (C64 33h vs REU 34h) -> 1 Next pulse, VerifyErr in cycle 2, DONE; with REU_VERIFY_EN undefined -> immediate DONE, VerifyErr=0.
- Stash 4 bytes, BA low 3 cycles after byte 1 -> nDMA stays 0, no strobes or pulses for 3 cycles, remaining 3 bytes resume, total 4 pulses.
- Reset asserted during SWAP_WR -> next edge IDLE, nDMA=1, no XferDone; ExecuteEN held high afterwards does not restart.

Source files
------------

// File: rtl/reu_dma_engine.sv
// REU DMA transfer sequencer: masters the C64 bus via nDMA/BA, drives SRAM strobes and
// returns per-byte advance pulses to the register block.
// State updates on the falling edge of PHI2; strobes are decoded from state and inputs.
// Optional build macro: REU_VERIFY_EN enables transfer type 11 (verify). Without it,
// type 11 completes immediately with no bus cycles and VerifyErr tied low.
module reu_dma_engine (
  input  logic        PHI2,
  input  logic        Reset,
  input  logic        ExecuteEN,
  input  logic        FF00DecodeEN,
  input  logic [1:0]  XferType,
  input  logic        Length1,
  input  logic [15:0] CA,
  input  logic [23:0] REUA,
  input  logic        FF00Wr,
  input  logic        BA,
  input  logic [7:0]  C64DIn,
  input  logic [7:0]  REUDIn,
  output logic        nDMA,
  output logic        C64AOE,
  output logic        C64RW,
  output logic        C64DOE,
  output logic [7:0]  C64DOut,
  output logic [23:0] RAMA,
  output logic        RAMnOE,
  output logic        RAMnWE,
  output logic [7:0]  RAMDOut,
  output logic        NextCA,
  output logic        NextREUA,
  output logic        VerifyErr,
  output logic        Busy,
  output logic        XferDone
);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWaitBa,
    StXfer,
    StSwapRd,
    StSwapWr,
    StDone
  } state_e;

  localparam logic [1:0] TypeStash  = 2'b00;
  localparam logic [1:0] TypeFetch  = 2'b01;
  localparam logic [1:0] TypeSwap   = 2'b10;
  localparam logic [1:0] TypeVerify = 2'b11;

  state_e     state_q, state_d;
  logic       exec_prev_q;
  logic [7:0] c64_lat_q, c64_lat_d;
  logic [7:0] ram_lat_q, ram_lat_d;
  logic       start;
  logic       byte_done;
  logic       verr;

  // CA is driven onto the C64 bus outside this block; only C64AOE is ours.
  logic unused_ca;
  assign unused_ca = ^CA;

  assign start = ExecuteEN && !exec_prev_q;
  assign RAMA  = REUA;
  assign Busy  = (state_q != StIdle);

  // Pulses are suppressed while Reset is asserted so an aborted byte is not counted.
  assign NextCA   = byte_done && !Reset;
  assign NextREUA = byte_done && !Reset;
  assign XferDone = (state_q == StDone) && !Reset;
`ifdef REU_VERIFY_EN
  assign VerifyErr = verr && !Reset;
`else
  assign VerifyErr = 1'b0;
`endif

  // State register, swap latches and Execute edge detector; all on falling PHI2.
  always_ff @(negedge PHI2) begin
    exec_prev_q <= ExecuteEN;
    if (Reset) begin
      state_q   <= StIdle;
      c64_lat_q <= 8'h00;
      ram_lat_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      c64_lat_q <= c64_lat_d;
      ram_lat_q <= ram_lat_d;
    end
  end

  // Next-state and strobe decode; BA low in a data state stalls with the bus idle.
  always_comb begin
    state_d   = state_q;
    c64_lat_d = c64_lat_q;
    ram_lat_d = ram_lat_q;
    nDMA      = 1'b1;
    C64AOE    = 1'b0;
    C64RW     = 1'b1;
    C64DOE    = 1'b0;
    C64DOut   = 8'h00;
    RAMnOE    = 1'b1;
    RAMnWE    = 1'b1;
    RAMDOut   = 8'h00;
    byte_done = 1'b0;
    verr      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = FF00DecodeEN ? StArm : StWaitBa;
      end

      StArm: begin
        if (FF00Wr)          state_d = StWaitBa;
        else if (!ExecuteEN) state_d = StIdle;
      end

      StWaitBa: begin
        nDMA = 1'b0;
        if (BA) begin
          case (XferType)
            TypeSwap:   state_d = StSwapRd;
`ifdef REU_VERIFY_EN
            TypeVerify: state_d = StXfer;
`else
            TypeVerify: state_d = StDone;
`endif
            default:    state_d = StXfer;
          endcase
        end
      end

      StXfer: begin
        nDMA = 1'b0;
        if (BA) begin
          C64AOE = 1'b1;
          case (XferType)
            TypeStash: begin
              RAMnWE    = 1'b0;
              RAMDOut   = C64DIn;
              byte_done = 1'b1;
            end
            TypeFetch: begin
              RAMnOE    = 1'b0;
              C64RW     = 1'b0;
              C64DOE    = 1'b1;
              C64DOut   = REUDIn;
              byte_done = 1'b1;
            end
`ifdef REU_VERIFY_EN
            TypeVerify: begin
              RAMnOE = 1'b0;
              if (C64DIn != REUDIn) begin
                verr    = 1'b1;
                state_d = StDone;
              end else begin
                byte_done = 1'b1;
              end
            end
`endif
            // Swap never reaches StXfer; bail out rather than hang.
            default: state_d = StDone;
          endcase
          if (byte_done && Length1) state_d = StDone;
        end
      end

      StSwapRd: begin
        nDMA = 1'b0;
        if (BA) begin
          C64AOE    = 1'b1;
          RAMnOE    = 1'b0;
          c64_lat_d = C64DIn;
          ram_lat_d = REUDIn;
          state_d   = StSwapWr;
        end
      end

      StSwapWr: begin
        nDMA = 1'b0;
        if (BA) begin
          C64AOE    = 1'b1;
          C64RW     = 1'b0;
          C64DOE    = 1'b1;
          C64DOut   = ram_lat_q;
          RAMnWE    = 1'b0;
          RAMDOut   = c64_lat_q;
          byte_done = 1'b1;
          state_d   = Length1 ? StDone : StSwapRd;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

endmodule
